// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into BYTES_PER_WORD-wide FIFO words through a one-word holding stage.
// Define UART_RX_PACK_TIMEOUT_EN to flush partial words after TIMEOUT_CYC idle cycles.
module uart_rx_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_rx_valid,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_fifo_full,
  output logic                        o_wren_fifo,
  output logic [BYTES_PER_WORD*8-1:0] o_rx_word,
  output logic [4:0]                  o_wr_bytes,
  input  logic                        i_ovf_clr,
  output logic                        o_overflow
);

  localparam int         W        = BYTES_PER_WORD * 8;
  localparam logic [4:0] LAST     = 5'(BYTES_PER_WORD - 1);
  localparam logic [4:0] FULL_CNT = 5'(BYTES_PER_WORD);

  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("uart_rx_packer: parameter out of range");
  end

  logic [W-1:0] r_asm;
  logic [4:0]   r_cnt;
  logic [W-1:0] r_hold;
  logic         r_hold_v;
  logic [4:0]   r_wr_bytes;
  logic         r_ovf;

  logic         w_drain;
  logic         w_last;
  logic         w_drop;
  logic         w_load;
  logic         w_flush;
  logic [4:0]   w_slot;
  logic [W-1:0] w_asm_wr;

  assign w_drain = r_hold_v & ~i_fifo_full;
  assign w_last  = i_rx_valid & (r_cnt == LAST);
  // A completing byte can only be kept if the holding stage is empty or emptying now
  assign w_drop  = w_last & r_hold_v & ~w_drain;
  assign w_load  = w_last & ~w_drop;
  assign w_slot  = (MSB_FIRST != 0) ? (LAST - r_cnt) : r_cnt;

  always_comb begin
    w_asm_wr = r_asm;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (5'(b) == w_slot) w_asm_wr[b*8 +: 8] = i_rx_data;
    end
  end

`ifdef UART_RX_PACK_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_idle;

  // Flush fires on the edge the idle count reaches TIMEOUT_CYC; it saturates while a hold is pending
  assign w_flush = ~i_rx_valid & (r_cnt != 5'd0) & (r_idle == IDLE_LAST) & (~r_hold_v | w_drain);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_idle <= '0;
    end else if (i_rx_valid || (r_cnt == 5'd0) || w_flush) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_LAST) begin
      r_idle <= r_idle + 16'd1;
    end
  end
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_hold_v   <= 1'b0;
      r_wr_bytes <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_load || w_flush) begin
        r_asm <= '0;
        r_cnt <= '0;
      end else if (i_rx_valid && !w_drop) begin
        r_asm <= w_asm_wr;
        r_cnt <= r_cnt + 5'd1;
      end

      if (w_load) begin
        r_hold     <= w_asm_wr;
        r_hold_v   <= 1'b1;
        r_wr_bytes <= FULL_CNT;
      end else if (w_flush) begin
        r_hold     <= r_asm;
        r_hold_v   <= 1'b1;
        r_wr_bytes <= r_cnt;
      end else if (w_drain) begin
        r_hold_v <= 1'b0;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_wren_fifo = w_drain;
  assign o_rx_word   = r_hold;
  assign o_wr_bytes  = r_wr_bytes;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: LSB-first and MSB-first instances share one stimulus stream.
module tb_uart_rx_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        fifo_full;
  logic        ovf_clr;

  logic        wren, m_wren;
  logic [31:0] word, m_word;
  logic [4:0]  wbytes, m_wbytes;
  logic        ovf, m_ovf;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int base;
  int idle_at;

  always #5 clk = ~clk;

  uart_rx_packer #(.BYTES_PER_WORD(4), .MSB_FIRST(0), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_fifo_full(fifo_full), .o_wren_fifo(wren), .o_rx_word(word),
    .o_wr_bytes(wbytes), .i_ovf_clr(ovf_clr), .o_overflow(ovf)
  );

  uart_rx_packer #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .TIMEOUT_CYC(16)) dut_m (
    .i_clk(clk), .i_rstn(rstn), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_fifo_full(fifo_full), .o_wren_fifo(m_wren), .o_rx_word(m_word),
    .o_wr_bytes(m_wbytes), .i_ovf_clr(ovf_clr), .o_overflow(m_ovf)
  );

  always @(posedge clk) if (wren) wr_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the strobe removed
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fifo_full = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wren", wren, 0);
    chk("rst_word", word, 0);
    chk("rst_bytes", wbytes, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic word, both byte orders
    base = wr_cnt;
    send(8'h11); send(8'h22); send(8'h33);
    chk("basic_pre_wren", wren, 0);
    send(8'h44);
    chk("basic_wren", wren, 1);
    chk("basic_word", word, 64'h44332211);
    chk("basic_bytes", wbytes, 4);
    chk("msb_wren", m_wren, 1);
    chk("msb_word", m_word, 64'h11223344);
    @(negedge clk);
    chk("basic_wren_1shot", wren, 0);
    chk("basic_wr_cnt", wr_cnt - base, 1);

    // FIFO full: hold stalls, eighth byte dropped; set beats clear in the same cycle
    fifo_full = 1'b1;
    base = wr_cnt;
    for (int i = 1; i <= 7; i++) send(8'(i));
    chk("full_wren", wren, 0);
    chk("full_ovf_pre", ovf, 0);
    ovf_clr = 1'b1;
    send(8'h08);
    ovf_clr = 1'b0;
    chk("full_ovf_set_wins", ovf, 1);
    chk("full_hold_word", word, 64'h04030201);
    chk("full_wr_none", wr_cnt - base, 0);
    fifo_full = 1'b0;
    #1;
    chk("release_wren", wren, 1);
    chk("release_word", word, 64'h04030201);
    @(negedge clk);
    chk("release_wren_1shot", wren, 0);
    chk("release_wr_cnt", wr_cnt - base, 1);
    send(8'h09);
    chk("after_drop_wren", wren, 1);
    chk("after_drop_word", word, 64'h09070605);
    @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Drain and completion in the same cycle
    fifo_full = 1'b1;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    send(8'hB1); send(8'hB2); send(8'hB3);
    base = wr_cnt;
    rx_valid = 1'b1; rx_data = 8'hB4; fifo_full = 1'b0;
    #1;
    chk("b2b_wren0", wren, 1);
    chk("b2b_word0", word, 64'hA4A3A2A1);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("b2b_wren1", wren, 1);
    chk("b2b_word1", word, 64'hB4B3B2B1);
    chk("b2b_ovf", ovf, 0);
    @(negedge clk);
    chk("b2b_wren_end", wren, 0);
    chk("b2b_wr_cnt", wr_cnt - base, 2);

    // Partial word and idle period
    base = wr_cnt;
    send(8'hAA); send(8'hBB);
    idle_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (idle_at == 0 && wren) begin
        idle_at = i;
        chk("to_word", word, 64'h0000BBAA);
        chk("to_bytes", wbytes, 2);
      end
      @(negedge clk);
    end
`ifdef UART_RX_PACK_TIMEOUT_EN
    chk("to_idle_cycle", idle_at, 17);
    chk("to_wr_cnt", wr_cnt - base, 1);
`else
    chk("noto_wr_cnt", wr_cnt - base, 0);
    send(8'hCC); send(8'hDD);
    chk("noto_wren", wren, 1);
    chk("noto_word", word, 64'hDDCCBBAA);
    chk("noto_bytes", wbytes, 4);
    @(negedge clk);
`endif

    // Reset with a pending hold, partial word and overflow
    fifo_full = 1'b1;
    send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("prerst_ovf", ovf, 1);
    #2;
    rstn = 1'b0; fifo_full = 1'b0;
    #1;
    chk("arst_wren", wren, 0);
    chk("arst_word", word, 0);
    chk("arst_bytes", wbytes, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_idle", wren, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("postrst_wren", wren, 1);
    chk("postrst_word", word, 64'h04030201);
    chk("postrst_msb_word", m_word, 64'h01020304);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 Parameter BYTES_PER_WORD, default 4, meaning number of received bytes packed into one FIFO word; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 0, meaning 0: first byte lands in bits [7:0]; 1: first byte lands in the top byte.
REQ-003 Parameter TIMEOUT_CYC, default 1024, meaning idle cycles before a partial word is flushed; legal range 2..65535; used only when the timeout feature is compiled in.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port i_rx_valid, input, 1 bit: one-cycle strobe, i_rx_data valid.
REQ-007 Port i_rx_data, input, 8 bits: received UART byte.
REQ-008 Port i_fifo_full, input, 1 bit: downstream FIFO full.
REQ-009 Port o_wren_fifo, output, 1 bit: FIFO write strobe.
REQ-010 Port o_rx_word, output, BYTES_PER_WORD*8 bits: packed word presented with o_wren_fifo.
REQ-011 Port o_wr_bytes, output, 5 bits: number of valid bytes in o_rx_word.
REQ-012 Port i_ovf_clr, input, 1 bit: clears o_overflow.
REQ-013 Port o_overflow, output, 1 bit: sticky; a byte was dropped.

Function
REQ-014 Datapath: assembly register plus byte counter cnt (0..BYTES_PER_WORD-1), and a holding register with flag hold_v.
REQ-015 Accepted byte: write it into slot cnt, or slot BYTES_PER_WORD-1-cnt when MSB_FIRST=1, then increment cnt.
REQ-016 Word completion: when the accepted byte fills the last slot, the full word moves to the holding register on the same edge, hold_v is set, o_wr_bytes=BYTES_PER_WORD, cnt returns to 0, and the assembly register clears to 0.
REQ-017 o_wren_fifo = hold_v AND NOT i_fifo_full (combinational); hold_v clears on the edge where o_wren_fifo=1.
REQ-018 Latency: a byte strobed in cycle N that completes a word produces o_wren_fifo in cycle N+1 when the FIFO is not full.
REQ-019 FIFO full: hold_v and o_rx_word stay stable, with no write, until i_fifo_full deasserts; collection continues in the assembly register.
REQ-020 Drain and completion in the same cycle: hold reloads with the new word, hold_v stays 1, no overflow.
REQ-021 Completion while hold_v=1 and not draining: the completing byte is dropped, cnt stays at BYTES_PER_WORD-1, and o_overflow sets on that edge.
REQ-022 o_overflow stays set until an i_ovf_clr cycle; if set and clear occur in the same cycle, set wins.
REQ-023 Unused slots of a partial word read as 0.

Reset
REQ-024 i_rstn low, asynchronously: cnt=0, assembly and holding registers=0, hold_v=0, o_wren_fifo=0, o_rx_word=0, o_wr_bytes=0, o_overflow=0, idle counter=0.
REQ-025 Reset in the middle of a word or while hold is pending discards all data; the first byte after reset goes to slot 0.

Configuration
REQ-026 Macro UART_RX_PACK_TIMEOUT_EN.
- Defined: an idle counter resets on every i_rx_valid and counts while cnt>0.
- When the idle counter reaches TIMEOUT_CYC with hold_v=0, the partial word moves to hold, o_wr_bytes=cnt, and cnt resets to 0.
- If hold_v=1 at that point, the flush waits until the hold drains.
- Any i_rx_valid in the flush cycle takes priority; the counter restarts.
REQ-027 Macro not defined: no idle counter and no flush logic; a partial word is held indefinitely; o_wr_bytes is always BYTES_PER_WORD when hold_v=1.

Verification
REQ-028 Defaults; bytes 0x11,0x22,0x33,0x44 with FIFO not full -> one o_wren_fifo, o_rx_word=0x44332211, o_wr_bytes=4, one cycle after the 0x44 strobe.
REQ-029 MSB_FIRST=1; same bytes -> o_rx_word=0x11223344.
REQ-030 i_fifo_full=1; send 8 bytes 0x01..0x08 -> no write; o_overflow sets on the 0x08 strobe. Release full -> one write of 0x04030201; cnt=3; 0x08 is lost.
REQ-031 Hold pending, i_fifo_full drops in the same cycle the next word completes -> two consecutive writes, o_overflow=0.
REQ-032 With UART_RX_PACK_TIMEOUT_EN and TIMEOUT_CYC=16: send 0xAA,0xBB, then idle -> write at idle cycle 16 with o_rx_word=0x0000BBAA, o_wr_bytes=2. Without the macro -> no write.
REQ-033 Assert i_rstn low after 2 bytes of a word, then release and send 4 bytes 0x01..0x04 -> o_rx_word=0x04030201, with no stale data.
